// File: rtl/nock_increment_pkg.sv
// Shared Nock memory/execute encodings used by the increment worker.
// Tag layout: bit7 = execute, bits[1:0] = hed/tel atom flags.
package nock_increment_pkg;

    localparam int TAG_TEL_ATOM = 0;
    localparam int TAG_HED_ATOM = 1;
    localparam int TAG_EXEC     = 7;

    localparam logic [1:0] CELL_CELL = 2'b00;
    localparam logic [1:0] CELL_ATOM = 2'b01;
    localparam logic [1:0] ATOM_CELL = 2'b10;
    localparam logic [1:0] ATOM_ATOM = 2'b11;

    localparam logic [27:0] NIL = 28'h0;

    localparam logic [1:0] MEM_NONE     = 2'd0;
    localparam logic [1:0] GET_CONTENTS = 2'd1;
    localparam logic [1:0] SET_CONTENTS = 2'd2;

    localparam logic [3:0] MUX_INCR = 4'd4;

    localparam logic [3:0] SYS_FUNC_TRAVERSE     = 4'h2;
    localparam logic [3:0] SYS_FUNC_EXECUTE      = 4'h3;
    localparam logic [3:0] SYS_TRAVERSE_POP      = 4'h2;
    localparam logic [3:0] SYS_EXECUTE_ERROR     = 4'hF;

    localparam logic [7:0] INCR_ERR_NONE = 8'h00;
    localparam logic [7:0] INCR_ERR_CELL = 8'h04;
    localparam logic [7:0] INCR_ERR_OVF  = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_CALC,
        ST_WRITE,
        ST_WR_WAIT,
        ST_DONE,
        ST_ERR
    } incr_state_t;

endpackage

// File: rtl/nock_increment.sv
// Nock opcode 4 worker: resolves [4 b] operand, increments it, rewrites the cell in place.
// Latency: direct 5 + write latency cycles; indirect adds read latency + 1. Start while busy is dropped.
module nock_increment
    import nock_increment_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NOUN_W = 28,
    parameter int TAG_W  = 8,
    parameter int DATA_W = TAG_W + 2*NOUN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] module_address,
    input  logic [DATA_W-1:0] module_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] read_data1,
    output logic              mem_execute,
    output logic [ADDR_W-1:0] address1,
    output logic [1:0]        mem_func,
    output logic [DATA_W-1:0] write_data,
    output logic              module_finished,
    output logic [3:0]        execute_return_sys_func,
    output logic [3:0]        execute_return_state,
    output logic [7:0]        error
);

    localparam int TAG_LSB = DATA_W - TAG_W;

    incr_state_t       state_q, state_d;
    logic [7:0]        err_code_d;
    logic [ADDR_W-1:0] cell_addr_q;
    logic [2:0]        tag_keep_q;
    logic [NOUN_W-1:0] operand_q;
    logic [NOUN_W-1:0] result_q;
    logic [TAG_W-1:0]  new_tag;

    wire [NOUN_W-1:0] in_tel   = module_data[NOUN_W-1:0];
    wire [NOUN_W-1:0] rd_hed   = read_data1[2*NOUN_W-1:NOUN_W];
    wire              in_direct = module_data[TAG_LSB + TAG_TEL_ATOM];
    wire              rd_atom   = read_data1[TAG_LSB + TAG_HED_ATOM];

    logic unused_bits;
    assign unused_bits = ^{module_data[DATA_W-1:NOUN_W], read_data1[DATA_W-1:TAG_LSB],
                           read_data1[NOUN_W-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = INCR_ERR_NONE;
        case (state_q)
            ST_IDLE:    if (start) state_d = in_direct ? ST_CALC : ST_RD_WAIT;
            ST_RD_WAIT: if (mem_ready) begin
                            if (rd_atom) state_d = ST_CALC;
                            else begin
                                state_d    = ST_ERR;
                                err_code_d = INCR_ERR_CELL;
                            end
                        end
            // Only direct atoms are handled; wrapping would need an indirect atom.
            ST_CALC:    if (&operand_q) begin
                            state_d    = ST_ERR;
                            err_code_d = INCR_ERR_OVF;
                        end else begin
                            state_d = ST_WRITE;
                        end
            ST_WRITE:   state_d = ST_WR_WAIT;
            ST_WR_WAIT: if (mem_ready) state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        module_finished = (state_q == ST_DONE) || (state_q == ST_ERR);
        new_tag         = {1'b0, tag_keep_q, 2'b00, ATOM_ATOM};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cell_addr_q             <= '0;
            tag_keep_q              <= '0;
            operand_q               <= '0;
            result_q                <= '0;
            mem_execute             <= 1'b0;
            mem_func                <= MEM_NONE;
            address1                <= '0;
            write_data              <= '0;
            execute_return_sys_func <= 4'h0;
            execute_return_state    <= 4'h0;
            error                   <= INCR_ERR_NONE;
        end else begin
            // Request strobe is a single-cycle pulse; address/data simply hold.
            mem_execute <= 1'b0;
            mem_func    <= MEM_NONE;
            case (state_q)
                ST_IDLE: if (start) begin
                    cell_addr_q             <= module_address;
                    tag_keep_q              <= module_data[TAG_LSB+6:TAG_LSB+4];
                    operand_q               <= in_tel;
                    error                   <= INCR_ERR_NONE;
                    execute_return_sys_func <= 4'h0;
                    execute_return_state    <= 4'h0;
                    if (!in_direct) begin
                        mem_execute <= 1'b1;
                        mem_func    <= GET_CONTENTS;
                        address1    <= in_tel[ADDR_W-1:0];
                    end
                end
                ST_RD_WAIT: if (mem_ready && rd_atom) operand_q <= rd_hed;
                ST_CALC:    result_q <= operand_q + NOUN_W'(1);
                ST_WRITE: begin
                    mem_execute <= 1'b1;
                    mem_func    <= SET_CONTENTS;
                    address1    <= cell_addr_q;
                    write_data  <= {new_tag, result_q, NOUN_W'(NIL)};
                end
                default: ;
            endcase
            if (state_d == ST_DONE) begin
                execute_return_sys_func <= SYS_FUNC_TRAVERSE;
                execute_return_state    <= SYS_TRAVERSE_POP;
            end
            if (state_d == ST_ERR) begin
                execute_return_sys_func <= SYS_FUNC_EXECUTE;
                execute_return_state    <= SYS_EXECUTE_ERROR;
                error                   <= err_code_d;
            end
        end
    end

endmodule

// File: tb/tb_nock_increment.sv
// Bench for nock_increment: memory responder with programmable latency plus a cell-level reference model.
module tb_nock_increment;
    import nock_increment_pkg::*;

    localparam int ADDR_W = 10;
    localparam int NOUN_W = 28;
    localparam int TAG_W  = 8;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] module_address;
    logic [DATA_W-1:0] module_data;
    logic              mem_ready;
    logic [DATA_W-1:0] read_data1;
    logic              mem_execute;
    logic [ADDR_W-1:0] address1;
    logic [1:0]        mem_func;
    logic [DATA_W-1:0] write_data;
    logic              module_finished;
    logic [3:0]        execute_return_sys_func;
    logic [3:0]        execute_return_state;
    logic [7:0]        error;

    always #5 clk = ~clk;

    nock_increment #(.ADDR_W(ADDR_W), .NOUN_W(NOUN_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .module_address(module_address), .module_data(module_data),
        .mem_ready(mem_ready), .read_data1(read_data1),
        .mem_execute(mem_execute), .address1(address1), .mem_func(mem_func),
        .write_data(write_data), .module_finished(module_finished),
        .execute_return_sys_func(execute_return_sys_func),
        .execute_return_state(execute_return_state), .error(error)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int                mem_lat = 1;
    int                get_cnt, set_cnt, exec_cycles, fin_cnt;
    logic [ADDR_W-1:0] last_get_addr, last_set_addr;
    logic [DATA_W-1:0] last_set_data;
    int                vectors = 0;
    int                miscompares = 0;

    initial forever begin
        @(negedge clk);
        if (mem_execute === 1'b1) exec_cycles++;
        if (module_finished === 1'b1) fin_cnt++;
    end

    initial begin : responder
        logic [1:0]        f;
        logic [ADDR_W-1:0] a;
        mem_ready  = 1'b0;
        read_data1 = '0;
        forever begin
            @(negedge clk);
            if (mem_execute === 1'b1) begin
                f = mem_func;
                a = address1;
                if (f == GET_CONTENTS) begin
                    get_cnt++;
                    last_get_addr = a;
                end else if (f == SET_CONTENTS) begin
                    set_cnt++;
                    last_set_addr = a;
                    last_set_data = write_data;
                    mem[a] = write_data;
                end
                repeat (mem_lat) @(negedge clk);
                read_data1 = mem[a];
                mem_ready  = 1'b1;
                @(negedge clk);
                mem_ready  = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [ADDR_W-1:0] addr, input logic [7:0] tag,
                          input logic [NOUN_W-1:0] hed, input logic [NOUN_W-1:0] tel,
                          input int lat, input string name);
        logic [DATA_W-1:0] ptr_word;
        logic [NOUN_W-1:0] op;
        logic [7:0]        exp_err;
        logic [DATA_W-1:0] exp_data;
        logic [3:0]        exp_func, exp_state;
        int                exp_gets, exp_sets, cyc;
        // Reference: resolve operand, then decide error or the rewritten cell.
        exp_err  = 8'h00;
        exp_gets = tag[0] ? 0 : 1;
        op       = tel;
        if (!tag[0]) begin
            ptr_word = mem[tel[ADDR_W-1:0]];
            op       = ptr_word[55:28];
            if (!ptr_word[57]) exp_err = 8'h04;
        end
        if (exp_err == 8'h00 && op == {NOUN_W{1'b1}}) exp_err = 8'h05;
        exp_sets  = (exp_err == 8'h00) ? 1 : 0;
        exp_data  = {(tag & 8'h70) | 8'h03, op + 28'd1, 28'd0};
        exp_func  = (exp_err == 8'h00) ? 4'h2 : 4'h3;
        exp_state = (exp_err == 8'h00) ? 4'h2 : 4'hF;

        mem_lat = lat;
        get_cnt = 0; set_cnt = 0; exec_cycles = 0; fin_cnt = 0;
        @(posedge clk); #1;
        module_address = addr;
        module_data    = {tag, hed, tel};
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (module_finished !== 1'b1 && cyc < 300);

        vectors++;
        if (module_finished !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: module_finished=%b after %0d cycles, required 1", name, module_finished, cyc);
        end
        vectors++;
        if (error !== exp_err) begin
            miscompares++;
            $display("FAIL %s error: got %h, required %h", name, error, exp_err);
        end
        vectors++;
        if (execute_return_sys_func !== exp_func || execute_return_state !== exp_state) begin
            miscompares++;
            $display("FAIL %s return: got %h/%h, required %h/%h", name,
                     execute_return_sys_func, execute_return_state, exp_func, exp_state);
        end

        repeat (lat + 6) @(negedge clk);
        vectors++;
        if (fin_cnt != 1) begin
            miscompares++;
            $display("FAIL %s finished_pulses: got %0d, required 1", name, fin_cnt);
        end
        vectors++;
        if (get_cnt != exp_gets || set_cnt != exp_sets) begin
            miscompares++;
            $display("FAIL %s mem_ops: got get=%0d set=%0d, required get=%0d set=%0d",
                     name, get_cnt, set_cnt, exp_gets, exp_sets);
        end
        vectors++;
        if (exec_cycles != exp_gets + exp_sets) begin
            miscompares++;
            $display("FAIL %s exec_cycles: got %0d, required %0d", name, exec_cycles, exp_gets + exp_sets);
        end
        if (exp_gets == 1) begin
            vectors++;
            if (last_get_addr !== tel[ADDR_W-1:0]) begin
                miscompares++;
                $display("FAIL %s get_addr: got %0d, required %0d", name, last_get_addr, tel[ADDR_W-1:0]);
            end
        end
        if (exp_sets == 1) begin
            vectors++;
            if (last_set_addr !== addr || last_set_data !== exp_data) begin
                miscompares++;
                $display("FAIL %s set: got @%0d %h, required @%0d %h", name,
                         last_set_addr, last_set_data, addr, exp_data);
            end
        end
        vectors++;
        if (error !== exp_err || execute_return_state !== exp_state) begin
            miscompares++;
            $display("FAIL %s held_outputs: got err=%h state=%h, required err=%h state=%h",
                     name, error, execute_return_state, exp_err, exp_state);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if (mem_execute !== 1'b0 || mem_func !== 2'd0 || module_finished !== 1'b0 ||
            error !== 8'h00 || execute_return_sys_func !== 4'h0 || execute_return_state !== 4'h0 ||
            address1 !== '0 || write_data !== '0) begin
            miscompares++;
            $display("FAIL %s: got exec=%b func=%0d fin=%b err=%h ret=%h/%h addr=%0d wd=%h, required all 0",
                     name, mem_execute, mem_func, module_finished, error,
                     execute_return_sys_func, execute_return_state, address1, write_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        module_address = '0;
        module_data = '0;
        #1;
        check_idle_outputs("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_direct();
        run_op(10'd12, 8'h83, 28'd4, 28'd41, 1, "direct");
    endtask

    task automatic test_indirect();
        mem[20] = {8'h03, 28'd99, 28'd0};
        run_op(10'd30, 8'h82, 28'd4, 28'd20, 2, "indirect");
    endtask

    task automatic test_operand_cell();
        mem[20] = {8'h01, 28'd77, 28'd5};
        run_op(10'd31, 8'h82, 28'd4, 28'd20, 1, "operand_cell");
    endtask

    task automatic test_overflow();
        run_op(10'd33, 8'h83, 28'd4, 28'hFFFFFFF, 1, "overflow");
        run_op(10'd34, 8'hF3, 28'd4, 28'hFFFFFFE, 1, "max_minus_one");
    endtask

    task automatic test_slow_mem();
        mem[50] = {8'h83, 28'd1234, 28'd0};
        run_op(10'd51, 8'h80, 28'd4, 28'd50, 5, "slow_mem");
    endtask

    task automatic test_random();
        logic [7:0]        tag;
        logic [NOUN_W-1:0] tel;
        logic [ADDR_W-1:0] addr;
        for (int i = 0; i < 24; i++) begin
            tag  = 8'($urandom);
            addr = ADDR_W'($urandom);
            if (tag[0]) begin
                tel = ($urandom_range(0, 5) == 0) ? {NOUN_W{1'b1}} : NOUN_W'($urandom);
            end else begin
                tel = NOUN_W'($urandom);
                while (tel[ADDR_W-1:0] == addr) tel = NOUN_W'($urandom);
                mem[tel[ADDR_W-1:0]] = {32'($urandom), 32'($urandom)};
                if ($urandom_range(0, 5) == 0) mem[tel[ADDR_W-1:0]][57:28] = {2'b11, {NOUN_W{1'b1}}};
            end
            run_op(addr, tag, NOUN_W'($urandom), tel, $urandom_range(1, 4), "random");
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        mem_lat = 10;
        @(posedge clk); #1;
        module_address = 10'd60;
        module_data    = {8'h83, 28'd4, 28'd7};
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(mem_execute === 1'b1 && mem_func === SET_CONTENTS) && cyc < 50);
        vectors++;
        if (mem_execute !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_set_issue: mem_execute=%b, required 1", mem_execute);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async");
        @(posedge clk); #1;
        check_idle_outputs("reset_mid_edge");
        @(posedge clk); #1;
        fin_cnt = 0;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        vectors++;
        if (fin_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_mid_stray_ready: finished pulses %0d, required 0", fin_cnt);
        end
        run_op(10'd61, 8'h81, 28'd9, 28'd0, 1, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {32'($urandom), 32'($urandom)};
        test_reset();
        test_direct();
        test_indirect();
        test_operand_cell();
        test_overflow();
        test_slow_mem();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
